// File: rtl/mskaes_128bits_round_ctrl_if.sv
// mskaes_128bits_round_ctrl_if: handshake, randomness and datapath-control bundle of the AES round controller
// MSKAES_CTRL_TRIG_EN adds the trig signal.
interface mskaes_128bits_round_ctrl_if #(
    parameter int d = 2
);
    logic           in_valid;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic           rnd_valid;
    logic           rnd_en;
    logic           sel_init;
    logic           sel_last;
    logic           state_en;
    logic [8*d-1:0] sh_RCON;
    logic [3:0]     round;
    logic           busy;
    logic           err;
`ifdef MSKAES_CTRL_TRIG_EN
    logic           trig;
`endif
    modport slave (
        input  in_valid, out_ready, rnd_valid,
        output in_ready, out_valid, rnd_en, sel_init, sel_last, state_en, sh_RCON, round, busy, err
`ifdef MSKAES_CTRL_TRIG_EN
        , output trig
`endif
    );
    modport master (
        output in_valid, out_ready, rnd_valid,
        input  in_ready, out_valid, rnd_en, sel_init, sel_last, state_en, sh_RCON, round, busy, err
`ifdef MSKAES_CTRL_TRIG_EN
        , input trig
`endif
    );
endinterface

// File: rtl/mskaes_128bits_round_ctrl.sv
// mskaes_128bits_round_ctrl: sequences 10 passes of the masked AES-128 round datapath for one block
// MSKAES_CTRL_TRIG_EN adds a registered trig output that is high during pass 1.
module mskaes_128bits_round_ctrl #(
    parameter int d       = 2,
    parameter int LATENCY = 4
) (
    input logic                        clk,
    input logic                        rst_n,
    mskaes_128bits_round_ctrl_if.slave io_ctrl
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [3:0] C_LAST = 4'(LATENCY - 1);
    // byte p holds the round constant of pass p; byte 0 and bytes 11..15 are unused
    localparam logic [127:0] RCON_TBL = {40'h0, 80'h361b8040201008040201, 8'h00};
    state_t     r_st;
    logic [3:0] r_p;
    logic [3:0] r_c;
    logic       r_err;
    logic       w_idle;
    logic       w_run;
    logic       w_load;
    logic       w_cap;
    logic [7:0] w_rc;
    assign w_idle = rst_n && r_st == IDLE;
    assign w_run  = r_st == RUN;
    assign w_load = w_run && r_c == C_LAST;
    assign w_cap  = w_idle && io_ctrl.in_valid && io_ctrl.rnd_valid;
    assign w_rc   = w_run ? RCON_TBL[{r_p, 3'b000} +: 8] : 8'h00;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st  <= IDLE;
            r_p   <= 4'd0;
            r_c   <= 4'd0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_run && !io_ctrl.rnd_valid;
            case (r_st)
                IDLE: if (w_cap) begin
                    r_st <= RUN;
                    r_p  <= 4'd1;
                    r_c  <= 4'd0;
                end
                RUN: if (!io_ctrl.rnd_valid) begin
                    // the gadget pipelines cannot stall, so an underrun kills the block
                    r_st <= IDLE;
                    r_p  <= 4'd0;
                    r_c  <= 4'd0;
                end else begin
                    r_c <= w_load ? 4'd0 : r_c + 4'd1;
                    if (w_load && r_p == 4'd10) r_st <= DONE;
                    else if (w_load) r_p <= r_p + 4'd1;
                end
                DONE: if (io_ctrl.out_ready) begin
                    r_st <= IDLE;
                    r_p  <= 4'd0;
                end
                default: r_st <= IDLE;
            endcase
        end
    end
    assign io_ctrl.in_ready  = w_idle && io_ctrl.rnd_valid;
    assign io_ctrl.sel_init  = w_cap;
    assign io_ctrl.state_en  = w_cap || w_load;
    assign io_ctrl.rnd_en    = w_run;
    assign io_ctrl.sel_last  = w_run && r_p == 4'd10;
    assign io_ctrl.out_valid = r_st == DONE;
    assign io_ctrl.busy      = r_st != IDLE;
    assign io_ctrl.round     = r_p;
    assign io_ctrl.err       = r_err;
    assign io_ctrl.sh_RCON   = (8*d)'(w_rc);
`ifdef MSKAES_CTRL_TRIG_EN
    logic r_trig;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_trig <= 1'b0;
        else r_trig <= w_cap || (w_run && io_ctrl.rnd_valid && r_p == 4'd1 && r_c != C_LAST);
    end
    assign io_ctrl.trig = r_trig;
`endif
endmodule

// File: tb/tb_mskaes_128bits_round_ctrl.sv
// tb_mskaes_128bits_round_ctrl: checks two controllers (LATENCY 4 and 1) against a pass-level model
// and a behavioural AES-128 datapath driven by their control outputs.
module tb_mskaes_128bits_round_ctrl;
    localparam int LAT = 4;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [87:0]  RCT = {80'h361b8040201008040201, 8'h00};
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    typedef struct packed {
        logic        in_ready;
        logic        out_valid;
        logic        rnd_en;
        logic        sel_init;
        logic        sel_last;
        logic        state_en;
        logic [15:0] rcon;
        logic [3:0]  round;
        logic        busy;
        logic        err;
        logic        trig;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic iv[2];
    logic rv[2];
    logic orr[2];
    outs_t o[2];
    int nchk = 0;
    int nerr = 0;
    int md[2];
    int kk[2];
    bit ef[2];
    logic [127:0] st[2];
    logic [127:0] ky[2];
    int nse[2];
    logic [7:0] rc_tr[200];
    logic sl_tr[200];

    always #5 clk = ~clk;

    mskaes_128bits_round_ctrl_if #(.d(2)) b0 ();
    mskaes_128bits_round_ctrl_if #(.d(2)) b1 ();
    mskaes_128bits_round_ctrl #(.d(2), .LATENCY(LAT)) u_dut0 (.clk(clk), .rst_n(rst_n), .io_ctrl(b0.slave));
    mskaes_128bits_round_ctrl #(.d(2), .LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io_ctrl(b1.slave));

    assign b0.in_valid  = iv[0];
    assign b0.rnd_valid = rv[0];
    assign b0.out_ready = orr[0];
    assign b1.in_valid  = iv[1];
    assign b1.rnd_valid = rv[1];
    assign b1.out_ready = orr[1];
`ifdef MSKAES_CTRL_TRIG_EN
    assign o[0] = {b0.in_ready, b0.out_valid, b0.rnd_en, b0.sel_init, b0.sel_last, b0.state_en,
                   b0.sh_RCON, b0.round, b0.busy, b0.err, b0.trig};
    assign o[1] = {b1.in_ready, b1.out_valid, b1.rnd_en, b1.sel_init, b1.sel_last, b1.state_en,
                   b1.sh_RCON, b1.round, b1.busy, b1.err, b1.trig};
`else
    assign o[0] = {b0.in_ready, b0.out_valid, b0.rnd_en, b0.sel_init, b0.sel_last, b0.state_en,
                   b0.sh_RCON, b0.round, b0.busy, b0.err, 1'b0};
    assign o[1] = {b1.in_ready, b1.out_valid, b1.rnd_en, b1.sel_init, b1.sel_last, b1.state_en,
                   b1.sh_RCON, b1.round, b1.busy, b1.err, 1'b0};
`endif

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] sbx(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX;
        return t[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [127:0] sb(input logic [127:0] s);
        for (int b = 0; b < 16; b++) s[8*b +: 8] = sbx(s[8*b +: 8]);
        return s;
    endfunction

    function automatic logic [127:0] sr(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
        return r;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mc(input logic [127:0] s);
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32*c -: 32];
            s[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return s;
    endfunction

    function automatic logic [127:0] ks(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        t = {sbx(w3[23:16]) ^ rc, sbx(w3[15:8]), sbx(w3[7:0]), sbx(w3[31:24])};
        w0 ^= t;
        w1 ^= w0;
        w2 ^= w1;
        w3 ^= w2;
        return {w0, w1, w2, w3};
    endfunction

    // behavioural datapath: applies the load the controller requests at the coming edge
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (o[i].state_en && o[i].sel_init) begin
                st[i] = PT;
                ky[i] = KEY;
                nse[i] = 1;
            end else if (o[i].state_en) begin
                st[i] = sr(sb(st[i] ^ ky[i]));
                if (!o[i].sel_last) st[i] = mc(st[i]);
                ky[i] = ks(ky[i], o[i].rcon[7:0]);
                nse[i]++;
            end
        end
    end

    // pass-level model: md 0 idle / 1 running / 2 done, kk = cycles since capture
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int L;
            int ps;
            outs_t e;
            L = (i == 1) ? 1 : LAT;
            e = '0;
            if (rst_n) begin
                e.err = ef[i];
                if (md[i] == 0) begin
                    e.in_ready = rv[i];
                    e.sel_init = iv[i] && rv[i];
                    e.state_en = iv[i] && rv[i];
                end else if (md[i] == 1) begin
                    ps = (kk[i] - 1) / L + 1;
                    e.rnd_en = 1'b1;
                    e.busy = 1'b1;
                    e.round = 4'(ps);
                    e.state_en = (kk[i] % L) == 0;
                    e.sel_last = ps == 10;
                    e.rcon = {8'h00, RCT[ps*8 +: 8]};
`ifdef MSKAES_CTRL_TRIG_EN
                    e.trig = ps == 1;
`endif
                end else begin
                    e.out_valid = 1'b1;
                    e.busy = 1'b1;
                    e.round = 4'd10;
                end
            end
            chk($sformatf("model%0d", i), o[i], e);
            if (!rst_n) begin
                md[i] = 0;
                kk[i] = 0;
                ef[i] = 1'b0;
            end else begin
                ef[i] = 1'b0;
                if (md[i] == 0 && iv[i] && rv[i]) begin
                    md[i] = 1;
                    kk[i] = 1;
                end else if (md[i] == 1 && !rv[i]) begin
                    md[i] = 0;
                    ef[i] = 1'b1;
                end else if (md[i] == 1 && kk[i] == 10 * L) md[i] = 2;
                else if (md[i] == 1) kk[i]++;
                else if (md[i] == 2 && orr[i]) md[i] = 0;
            end
        end
    end

    task automatic run_block(input int i, input int hold, output logic [127:0] ct, output int lat, output int tg);
        @(posedge clk); #1;
        iv[i] = 1'b1;
        orr[i] = hold == 0;
        @(posedge clk); #1;
        iv[i] = 1'b0;
        lat = 200;
        tg = 0;
        for (int n = 1; n < 200; n++) begin
            @(negedge clk);
            rc_tr[n] = o[i].rcon[7:0];
            sl_tr[n] = o[i].sel_last;
            if (o[i].out_valid) begin
                lat = n;
                break;
            end
            tg += int'(o[i].trig);
            @(posedge clk); #1;
        end
        ct = st[i] ^ ky[i];
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("hold_ov", o[i].out_valid, 1);
                chk("hold_ir", o[i].in_ready, 0);
                chk("hold_round", o[i].round, 10);
            end
            @(posedge clk); #1;
            orr[i] = 1'b1;
            @(negedge clk);
            chk("release_ir", o[i].in_ready, 0);
        end
        @(posedge clk); #1;
        orr[i] = 1'b1;
        @(negedge clk);
        chk("idle_ir", o[i].in_ready, 1);
        chk("idle_ov", o[i].out_valid, 0);
    endtask

    initial begin
        logic [127:0] ct;
        int lat, tg, ne, nv;
        iv = '{1'b0, 1'b0};
        rv = '{1'b1, 1'b1};
        orr = '{1'b1, 1'b1};
        #3;
        chk("rst_init0", o[0], 0);
        chk("rst_init1", o[1], 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        run_block(0, 0, ct, lat, tg);
        chk("fips_ct", ct, CT);
        chk("fips_lat", lat, 41);
        chk("fips_nse", nse[0], 11);
        chk("rcon_p1a", rc_tr[1], 8'h01);
        chk("rcon_p1b", rc_tr[4], 8'h01);
        chk("rcon_p2", rc_tr[5], 8'h02);
        chk("rcon_p9", rc_tr[36], 8'h1b);
        chk("rcon_p10a", rc_tr[37], 8'h36);
        chk("rcon_p10b", rc_tr[40], 8'h36);
        chk("last_36", sl_tr[36], 0);
        chk("last_37", sl_tr[37], 1);
        chk("last_40", sl_tr[40], 1);
`ifdef MSKAES_CTRL_TRIG_EN
        chk("trig_len0", tg, 4);
`endif

        run_block(0, 20, ct, lat, tg);
        chk("hold_ct", ct, CT);

        @(posedge clk); #1;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        repeat (4 * LAT + 1) @(posedge clk);
        #1;
        rv[0] = 1'b0;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        rv[0] = 1'b1;
        @(negedge clk);
        chk("abort_err", o[0].err, 1);
        chk("abort_busy", o[0].busy, 0);
        ne = 0;
        nv = 0;
        repeat (60) begin
            @(negedge clk);
            ne += int'(o[0].err);
            nv += int'(o[0].out_valid);
        end
        chk("abort_err_once", ne, 0);
        chk("abort_no_ov", nv, 0);
        run_block(0, 0, ct, lat, tg);
        chk("after_abort_ct", ct, CT);

        @(posedge clk); #1;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (6 * LAT + 1) @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_round", o[0].round, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async0", o[0], 0);
        chk("rst_async1", o[1], 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_block(0, 0, ct, lat, tg);
        chk("after_rst_ct", ct, CT);
        chk("after_rst_lat", lat, 41);

        run_block(1, 0, ct, lat, tg);
        chk("lat1_ct", ct, CT);
        chk("lat1_lat", lat, 11);
        chk("lat1_nse", nse[1], 11);
`ifdef MSKAES_CTRL_TRIG_EN
        chk("trig_len1", tg, 1);
`endif
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d of %0d checks", nerr, nchk);
        $fatal(1);
    end
endmodule

// File: doc/mskaes_128bits_round_ctrl.md
Name: mskaes_128bits_round_ctrl

Overview:
Control FSM that sequences the masked 128-bit AES round datapath (AK/SB/SR/MC plus key-schedule round) over 10 passes to encrypt one block.
- Drives the shared state/key register enables, the init/last-round multiplexer selects and the shared round constant.
- Runs the valid/ready handshakes toward the block source and sink.
- Supervises the randomness feed for the SB/KS gadgets.
- Handles only non-secret control; no share data passes through it, except the constant RCON sharing.

Parameters:
d, 2, number of shares; sets the width of sh_RCON
LATENCY, 4, pipeline depth in cycles of one round pass (SB and KS); legal range 1..15

Ports:
clk  in  1  clock; all state changes on its rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  plaintext and key shares presented at datapath input
in_ready  out  1  block accepted when in_valid and in_ready are both high
out_valid  out  1  ciphertext shares valid at datapath AK output
out_ready  in  1  sink accepts the ciphertext
rnd_valid  in  1  PRNG delivering fresh randomness this cycle
rnd_en  out  1  PRNG advance request
sel_init  out  1  datapath state/key registers select external input (high only in the capture cycle)
sel_last  out  1  state register takes the SR output instead of the MC output (pass 10)
state_en  out  1  load enable for the shared state and key registers
sh_RCON  out  8*d  shared round constant; share 0 = RCON byte, all other shares 0
round  out  4  current pass number, 1..10; 0 when not running
busy  out  1  high in RUN and DONE
err  out  1  one-cycle pulse on randomness underrun abort

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state IDLE, pass counter p=0, cycle counter c=0.
  - All outputs 0, including in_ready, out_valid, err.
  - sh_RCON is all zero.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = rnd_valid.
  - On in_valid && in_ready: sel_init=1 and state_en=1 in that cycle (registers capture plaintext and key).
  - Next state RUN with p=1, c=0.
- RUN:
  - rnd_en=1 on every RUN cycle.
  - c increments each cycle and wraps from LATENCY-1 to 0.
  - state_en=1 only when c==LATENCY-1.
  - At that load: if p<10 then p increments; if p==10 go to DONE.
  - With LATENCY=1, c stays 0 and state_en is high on every RUN cycle.
- sel_last = (p==10) while in RUN; otherwise 0.
- RCON:
  - sh_RCON byte during pass p: 01,02,04,08,10,20,40,80,1B,36 for p=1..10.
  - Held constant across all LATENCY cycles of a pass.
  - 00 outside RUN.
- round = p in RUN and DONE; 0 in IDLE.
- DONE:
  - out_valid=1 (data = AK output = final state XOR k10, combinational in datapath); state_en=0.
  - On out_valid && out_ready: go to IDLE. in_ready may rise in the following cycle only, never in the same cycle, so no input is accepted while output is pending.
- Latency: capture at cycle T gives out_valid first high at cycle T+10*LATENCY+1 (LATENCY=4: T+41).
- Randomness underrun: rnd_valid low during any RUN cycle triggers an abort.
  - err pulses 1 in the next cycle; next state IDLE; p and c cleared; out_valid never raised for that block.
  - The gadget pipelines cannot stall, so no wait state exists.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values; the pending block is discarded.
- in_valid while busy: ignored; in_ready stays 0.

Optional Feature:
MSKAES_CTRL_TRIG_EN
- Defined: adds output port trig (1 bit), registered, for side-channel capture alignment.
  - trig is high exactly during pass 1 (LATENCY cycles starting at cycle T+1).
  - It clears on abort or reset.
- Undefined: the trig port and its register are absent; all other behaviour is identical.

Test Plan:
- LATENCY=4, d=2, FIPS-197 C.1 vector (pt 00112233..ff, key 00010203..0f), random share masks, rnd_valid=1, out_ready=1 -> out_valid at T+41, unmasked output 69c4e0d8..c55a; exactly 11 state_en pulses (capture + 10 passes).
- Same run, sample sh_RCON and round -> share 0 shows 01,02,..,1B,36 each held 4 cycles; share 1 always 00; sel_last high only for cycles T+37..T+40.
- Hold out_ready=0 for 20 cycles after completion -> out_valid stays 1, in_ready stays 0, round=10; release -> IDLE next cycle, in_ready=1 in the following cycle.
- Drop rnd_valid for 1 cycle at pass 5 -> err pulse 1 cycle, no out_valid, IDLE; the next block completes correctly.
- Assert rst_n=0 asynchronously at pass 7 -> all outputs 0 immediately; after release the FIPS vector passes again.
- LATENCY=1 build -> state_en high on 10 consecutive RUN cycles, out_valid at T+11, correct ciphertext; with MSKAES_CTRL_TRIG_EN, trig high for exactly 1 cycle.
